fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage.sv | 156 +++++++++++++++
 tb/tb_fetch_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Purpose:
//    Instruction fetch front end. Issues one instruction-memory request at a
//    time, buffers the returned word, and presents it to decode until decode
//    accepts it. A redirect from execute replaces the PC and causes any
//    in-flight response to be dropped.
//
// Ports:
//    CLK          in   single clock, rising-edge
//    RST_N        in   asynchronous active-low reset
//    StallF       in   decode cannot take the presented instruction
//    PCSrcE       in   redirect request
//    PCTargetE    in   redirect target (low two bits ignored)
//    IMemReq      out  instruction-memory request valid
//    IMemAddr     out  request address (word aligned)
//    IMemRdy      in   memory accepts the request this cycle
//    IMemRValid   in   IMemRData carries a response
//    IMemRData    in   returned instruction word
//    InstrF       out  fetched instruction, NOP_INSTR when not valid
//    InstrValidF  out  InstrF holds a valid instruction
//    PCF          out  current fetch PC
//    PCPlus4F     out  PCF + 4 (wraps modulo 2^32)
// ---------------------------------------------------------------------------
module fetch_stage #(
   parameter logic [31:0] RESET_VECTOR = 32'h00000000,
   parameter logic [31:0] NOP_INSTR    = 32'h00000013
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        StallF,
   input  logic        PCSrcE,
   input  logic [31:0] PCTargetE,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemRdy,
   input  logic        IMemRValid,
   input  logic [31:0] IMemRData,
   output logic [31:0] InstrF,
   output logic        InstrValidF,
   output logic [31:0] PCF,
   output logic [31:0] PCPlus4F
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      WAIT  = 2'd2,
      VALID = 2'd3
   } fetchState_e;

   fetchState_e state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        drop_q, drop_d;
   logic [31:0] buf_q, buf_d;

   logic [31:0] redirectPc;
   logic [31:0] pcPlus4;

   assign redirectPc = {PCTargetE[31:2], 2'b00};
   assign pcPlus4    = pc_q + 32'd4;

   // Next-state logic. A redirect always wins over stall and normal
   // sequencing. The drop flag remembers that an accepted request belongs to
   // a stale PC so its response must be thrown away rather than buffered;
   // this keeps at most one request outstanding at any time.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      buf_d   = buf_q;

      unique case (state_q)
         IDLE: begin
            if (PCSrcE) begin
               pc_d = redirectPc;
            end
            state_d = REQ;
         end

         REQ: begin
            if (PCSrcE) begin
               pc_d = redirectPc;
               if (IMemRdy) begin
                  drop_d  = 1'b1;
                  state_d = WAIT;
               end
            end else if (IMemRdy) begin
               state_d = WAIT;
            end
         end

         WAIT: begin
            if (PCSrcE) begin
               pc_d = redirectPc;
               if (IMemRValid) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  drop_d = 1'b1;
               end
            end else if (IMemRValid) begin
               if (drop_q) begin
                  drop_d  = 1'b0;
                  state_d = REQ;
               end else begin
                  buf_d   = IMemRData;
                  state_d = VALID;
               end
            end
         end

         VALID: begin
            if (PCSrcE) begin
               pc_d    = redirectPc;
               state_d = REQ;
            end else if (!StallF) begin
               pc_d    = pcPlus4;
               state_d = REQ;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State registers; reset forces the idle state immediately, even with a
   // request in flight, so a later response arrives outside WAIT and is
   // ignored.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         pc_q    <= RESET_VECTOR;
         drop_q  <= 1'b0;
         buf_q   <= NOP_INSTR;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         drop_q  <= drop_d;
         buf_q   <= buf_d;
      end
   end

   // Outputs decode only registered state, so none of them depend
   // combinationally on the memory handshake inputs.
   assign IMemReq     = (state_q == REQ);
   assign IMemAddr    = pc_q;
   assign InstrValidF = (state_q == VALID);
   assign InstrF      = (state_q == VALID) ? buf_q : NOP_INSTR;
   assign PCF         = pc_q;
   assign PCPlus4F    = pcPlus4;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Directed testbench for fetch_stage. The bench plays the instruction memory
// by hand, cycle by cycle, and compares outputs against hand-computed values.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

   logic        CLK;
   logic        RST_N;
   logic        StallF;
   logic        PCSrcE;
   logic [31:0] PCTargetE;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemRdy;
   logic        IMemRValid;
   logic [31:0] IMemRData;
   logic [31:0] InstrF;
   logic        InstrValidF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;

   int checkCount = 0;
   int passCount  = 0;

   localparam logic [31:0] NOP = 32'h00000013;

   fetch_stage #(
      .RESET_VECTOR(32'h00000000),
      .NOP_INSTR   (NOP)
   ) dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .StallF     (StallF),
      .PCSrcE     (PCSrcE),
      .PCTargetE  (PCTargetE),
      .IMemReq    (IMemReq),
      .IMemAddr   (IMemAddr),
      .IMemRdy    (IMemRdy),
      .IMemRValid (IMemRValid),
      .IMemRData  (IMemRData),
      .InstrF     (InstrF),
      .InstrValidF(InstrValidF),
      .PCF        (PCF),
      .PCPlus4F   (PCPlus4F)
   );

   // Free-running clock, 10 time-unit period.
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] got,
                              input logic [31:0] exp);
      checkCount++;
      if (got === exp) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock and settle just after the edge.
   task automatic applyStimulus();
      @(posedge CLK);
      #1;
   endtask

   initial begin
      RST_N      = 1'b0;
      StallF     = 1'b0;
      PCSrcE     = 1'b0;
      PCTargetE  = 32'h0;
      IMemRdy    = 1'b0;
      IMemRValid = 1'b0;
      IMemRData  = 32'h0;

      // Reset state
      applyStimulus();
      applyStimulus();
      checkOutput("rst_req",    {31'b0, IMemReq},     32'd0);
      checkOutput("rst_valid",  {31'b0, InstrValidF}, 32'd0);
      checkOutput("rst_instr",  InstrF,               NOP);
      checkOutput("rst_pcf",    PCF,                  32'h0);
      checkOutput("rst_pcp4",   PCPlus4F,             32'h4);

      // Release: IDLE for one cycle, first request in the second cycle
      RST_N = 1'b1;
      #1;
      checkOutput("idle_req",   {31'b0, IMemReq},     32'd0);
      applyStimulus();
      checkOutput("first_req",  {31'b0, IMemReq},     32'd1);
      checkOutput("first_addr", IMemAddr,             32'h0);

      // Accept, respond one cycle later, valid two cycles after acceptance
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy    = 1'b0;
      checkOutput("wait_req",   {31'b0, IMemReq},     32'd0);
      checkOutput("wait_valid", {31'b0, InstrValidF}, 32'd0);
      IMemRValid = 1'b1;
      IMemRData  = 32'h00500093;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("lat_valid",  {31'b0, InstrValidF}, 32'd1);
      checkOutput("lat_instr",  InstrF,               32'h00500093);
      checkOutput("lat_pcf",    PCF,                  32'h0);
      checkOutput("lat_pcp4",   PCPlus4F,             32'h4);

      // Stall in VALID for three cycles holds everything
      StallF = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("stall_valid", {31'b0, InstrValidF}, 32'd1);
         checkOutput("stall_instr", InstrF,               32'h00500093);
         checkOutput("stall_pcf",   PCF,                  32'h0);
         checkOutput("stall_req",   {31'b0, IMemReq},     32'd0);
      end
      StallF = 1'b0;
      applyStimulus();
      checkOutput("adv_req",    {31'b0, IMemReq},     32'd1);
      checkOutput("adv_addr",   IMemAddr,             32'h4);
      checkOutput("adv_valid",  {31'b0, InstrValidF}, 32'd0);

      // Redirect while waiting, stale response dropped
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy   = 1'b0;
      PCSrcE    = 1'b1;
      PCTargetE = 32'h00000100;
      applyStimulus();
      PCSrcE = 1'b0;
      checkOutput("rdw_req",    {31'b0, IMemReq},     32'd0);
      IMemRValid = 1'b1;
      IMemRData  = 32'hDEADBEEF;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("drop_valid", {31'b0, InstrValidF}, 32'd0);
      checkOutput("drop_instr", InstrF,               NOP);
      checkOutput("drop_req",   {31'b0, IMemReq},     32'd1);
      checkOutput("drop_addr",  IMemAddr,             32'h100);
      applyStimulus();
      checkOutput("drop_hold",  {31'b0, InstrValidF}, 32'd0);

      // Redirect in REQ without Rdy, misaligned target is word-aligned
      PCSrcE    = 1'b1;
      PCTargetE = 32'h00000203;
      applyStimulus();
      PCSrcE = 1'b0;
      checkOutput("rdq_pcf",    PCF,                  32'h200);
      checkOutput("rdq_req",    {31'b0, IMemReq},     32'd1);
      checkOutput("rdq_addr",   IMemAddr,             32'h200);

      // Address held while memory is not ready; response outside WAIT ignored
      IMemRValid = 1'b1;
      IMemRData  = 32'h55555555;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("hold_addr",  IMemAddr,             32'h200);
      checkOutput("ign_valid",  {31'b0, InstrValidF}, 32'd0);

      // Wrap at the top of the address space
      PCSrcE    = 1'b1;
      PCTargetE = 32'hFFFFFFFC;
      applyStimulus();
      PCSrcE = 1'b0;
      checkOutput("wrap_pcf",   PCF,                  32'hFFFFFFFC);
      checkOutput("wrap_pcp4",  PCPlus4F,             32'h0);
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy    = 1'b0;
      IMemRValid = 1'b1;
      IMemRData  = 32'h11111111;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("wrap_instr", InstrF,               32'h11111111);
      applyStimulus();
      checkOutput("wrap_req",   {31'b0, IMemReq},     32'd1);
      checkOutput("wrap_addr",  IMemAddr,             32'h0);

      // Redirect in VALID beats a simultaneous stall
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy    = 1'b0;
      IMemRValid = 1'b1;
      IMemRData  = 32'h22222222;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("v2_instr",   InstrF,               32'h22222222);
      StallF    = 1'b1;
      PCSrcE    = 1'b1;
      PCTargetE = 32'h00000103;
      applyStimulus();
      StallF = 1'b0;
      PCSrcE = 1'b0;
      checkOutput("rdv_pcf",    PCF,                  32'h100);
      checkOutput("rdv_valid",  {31'b0, InstrValidF}, 32'd0);
      checkOutput("rdv_req",    {31'b0, IMemReq},     32'd1);

      // Redirect in REQ while memory accepts: response must be dropped
      PCSrcE    = 1'b1;
      PCTargetE = 32'h00000300;
      IMemRdy   = 1'b1;
      applyStimulus();
      PCSrcE  = 1'b0;
      IMemRdy = 1'b0;
      IMemRValid = 1'b1;
      IMemRData  = 32'h33333333;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("rqa_valid",  {31'b0, InstrValidF}, 32'd0);
      checkOutput("rqa_addr",   IMemAddr,             32'h300);
      checkOutput("rqa_req",    {31'b0, IMemReq},     32'd1);

      // Reset pulse mid-request, stale response after release ignored
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy = 1'b0;
      RST_N   = 1'b0;
      #1;
      checkOutput("mrst_req",   {31'b0, IMemReq},     32'd0);
      checkOutput("mrst_pcf",   PCF,                  32'h0);
      checkOutput("mrst_instr", InstrF,               NOP);
      applyStimulus();
      RST_N      = 1'b1;
      IMemRValid = 1'b1;
      IMemRData  = 32'h77777777;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("stale_valid", {31'b0, InstrValidF}, 32'd0);
      checkOutput("stale_req",   {31'b0, IMemReq},     32'd1);
      checkOutput("stale_addr",  IMemAddr,             32'h0);
      IMemRdy = 1'b1;
      applyStimulus();
      IMemRdy    = 1'b0;
      IMemRValid = 1'b1;
      IMemRData  = 32'h44444444;
      applyStimulus();
      IMemRValid = 1'b0;
      checkOutput("restart_instr", InstrF,            32'h44444444);
      checkOutput("restart_pcf",   PCF,               32'h0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
